// File: rtl/wb_mgmt_la_arbiter_pkg.sv
// Shared types and defaults for the management/LA Wishbone arbiter.
// Optional watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
package soc_now_wb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_mgmt_la_arbiter_if.sv
// Wishbone classic bus bundle; master drives the request, slave drives ack/read data.
interface wb_mgmt_la_arbiter_if #(
    parameter int AW = soc_now_wb_pkg::AW_DEF,
    parameter int DW = soc_now_wb_pkg::DW_DEF
) ();

    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );

endinterface

// File: rtl/wb_mgmt_la_arbiter_watchdog.sv
// Stall watchdog: counts stalled strobe cycles and pulses fire_o on the terminal count.
// Only built when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = soc_now_wb_pkg::TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic fire_o,
    output logic timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          timeout_q, timeout_d;
    logic          stall;
    logic          fire;

    assign stall = active_i & stb_i & ~ack_i;
    // The fire cycle is itself the N-th stalled cycle, hence compare against N-1.
    assign fire  = stall & (count_q == LAST);

    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q | fire;
        if (!active_i || ack_i || fire) begin
            count_d = '0;
        end else if (stall) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign fire_o    = fire;
    assign timeout_o = timeout_q;

endmodule
`endif

// File: rtl/wb_mgmt_la_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = management SoC, m1 = LA debug master).
// Define WB_ARB_TIMEOUT_EN to add the stalled-transfer watchdog.
module wb_mgmt_la_arbiter
    import soc_now_wb_pkg::*;
#(
    parameter int              AW             = AW_DEF,
    parameter int              DW             = DW_DEF,
    parameter int              TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [DW-1:0]   TIMEOUT_DATA   = DW'(TIMEOUT_DATA_DEF)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_mgmt_la_arbiter_if.slave   m0,
    wb_mgmt_la_arbiter_if.slave   m1,
    wb_mgmt_la_arbiter_if.master  s,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_GNT0 = GNT0;
    localparam logic [1:0] ST_GNT1 = GNT1;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;   // 0: m0 owned last, 1: m1 owned last

    logic            mux_cyc;
    logic            mux_stb;
    logic            mux_we;
    logic [DW/8-1:0] mux_sel;
    logic [AW-1:0]   mux_adr;
    logic [DW-1:0]   mux_dat;
    logic            wd_fire;

    logic [1:0]      m_ack;
    logic [DW-1:0]   m_dat [2];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && (!m1.cyc || last_grant_q)) begin
                    state_d = ST_GNT0;
                end else if (m1.cyc) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0.cyc) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o = {state_q == ST_GNT1, state_q == ST_GNT0};

    // Slave side follows the registered owner; everything is zero while idle.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_sel = '0;
        mux_adr = '0;
        mux_dat = '0;
        case (state_q)
            ST_GNT0: begin
                mux_cyc = m0.cyc;
                mux_stb = m0.stb;
                mux_we  = m0.we;
                mux_sel = m0.sel;
                mux_adr = m0.adr;
                mux_dat = m0.dat_w;
            end
            ST_GNT1: begin
                mux_cyc = m1.cyc;
                mux_stb = m1.stb;
                mux_we  = m1.we;
                mux_sel = m1.sel;
                mux_adr = m1.adr;
                mux_dat = m1.dat_w;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .active_i  (mux_cyc),
        .stb_i     (mux_stb),
        .ack_i     (s.ack),
        .fire_o    (wd_fire),
        .timeout_o (timeout_o)
    );
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign s.cyc   = mux_cyc;
    assign s.stb   = mux_stb & ~wd_fire;
    assign s.we    = mux_we;
    assign s.sel   = mux_sel;
    assign s.adr   = mux_adr;
    assign s.dat_w = mux_dat;

    // Watchdog termination looks like a normal ack carrying the sentinel word.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign m_ack[gi] = grant_o[gi] & (s.ack | wd_fire);
            assign m_dat[gi] = !grant_o[gi] ? '0 :
                               wd_fire      ? TIMEOUT_DATA : s.dat_r;
        end
    endgenerate

    assign m0.ack   = m_ack[0];
    assign m0.dat_r = m_dat[0];
    assign m1.ack   = m_ack[1];
    assign m1.dat_r = m_dat[1];

endmodule
